// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the unlock-sequence controller.
package lock_pkg;

  typedef enum logic [1:0] {
    StLocked,
    StArmed,
    StUnlocked,
    StLockout
  } lock_state_e;

  // Timer must hold the larger of the arm timeout and the unlock window.
  function automatic int unsigned timer_width(int unsigned arm_cycles, int unsigned win_cycles);
    int unsigned max_cycles;
    max_cycles = (arm_cycles > win_cycles) ? arm_cycles : win_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/lock_window_timer.sv
// Loadable down-counter shared by the arm timeout and the unlock window.
module lock_window_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic         running;

  assign running = |count_q;
  assign expire  = running && (count_q == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (clr) begin
      count_q <= '0;
    end else if (running) begin
      count_q <= count_q - W'(1);
    end
  end

endmodule

// File: rtl/lock_ctrl.sv
// Unlock-sequence controller: gates writes to a locked register behind a two-word key
// and a time-limited window, with sticky lockout after repeated failures.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned             DATA_W        = 1,
  parameter int unsigned             KEY_W         = 16,
  parameter logic        [KEY_W-1:0] KEY_A         = 16'hA5A5,
  parameter logic        [KEY_W-1:0] KEY_B         = 16'h5A5A,
  parameter int unsigned             ARM_TIMEOUT   = 4,
  parameter int unsigned             UNLOCK_CYCLES = 8,
  parameter int unsigned             MAX_FAIL      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [KEY_W-1:0]              key_data,
  input  logic                          wr_req,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          relock,
  output logic                          write_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          unlocked,
  output logic                          lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int unsigned TW = timer_width(ARM_TIMEOUT, UNLOCK_CYCLES);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  lock_state_e       state_q;
  logic [FW-1:0]     fail_cnt_q;
  logic              write_en_q;
  logic [DATA_W-1:0] data_q;

  logic          key_a, key_b, fail_ev, expire;
  logic          timer_load, timer_clr;
  logic [TW-1:0] timer_val;
  logic [FW-1:0] fail_inc;

  always_comb begin
    key_a      = key_valid && (key_data == KEY_A);
    key_b      = key_valid && (key_data == KEY_B);
    fail_ev    = 1'b0;
    timer_load = 1'b0;
    timer_clr  = 1'b0;
    timer_val  = '0;
    fail_inc   = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FW'(1);
    case (state_q)
      StLocked: begin
        if (key_a) begin
          timer_load = 1'b1;
          timer_val  = TW'(ARM_TIMEOUT);
        end else if (key_valid) begin
          fail_ev = 1'b1;
        end
      end
      StArmed: begin
        if (relock) begin
          timer_clr = 1'b1;
        end else if (key_b) begin
          timer_load = 1'b1;
          timer_val  = TW'(UNLOCK_CYCLES);
        end else if (key_valid || expire) begin
          fail_ev   = 1'b1;
          timer_clr = 1'b1;
        end
      end
      StUnlocked: timer_clr = relock || expire;
      default: ;
    endcase
  end

  lock_window_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .clr      (timer_clr),
    .load_val (timer_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLocked;
      fail_cnt_q <= '0;
      write_en_q <= 1'b0;
      data_q     <= '0;
    end else begin
      write_en_q <= 1'b0;
      if ((state_q == StUnlocked) && wr_req && !relock) begin
        write_en_q <= 1'b1;
        data_q     <= wr_data;
      end
      case (state_q)
        StLocked: if (key_a) state_q <= StArmed;
        StArmed: begin
          if (relock) begin
            state_q <= StLocked;
          end else if (key_b) begin
            state_q    <= StUnlocked;
            fail_cnt_q <= '0;
          end
        end
        StUnlocked: if (relock || expire) state_q <= StLocked;
        default: ;
      endcase
      // A fail event overrides whatever transition the case above chose.
      if (fail_ev) begin
        fail_cnt_q <= fail_inc;
        state_q    <= (fail_inc == FW'(MAX_FAIL)) ? StLockout : StLocked;
      end
    end
  end

  assign write_en = write_en_q;
  assign data_out = data_q;
  assign unlocked = (state_q == StUnlocked);
  assign lockout  = (state_q == StLockout);
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Table-driven bench for lock_ctrl with an expected-result queue per applied vector.
module tb_lock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [15:0] key_data;
  logic        wr_req;
  logic [0:0]  wr_data;
  logic        relock;
  logic        write_en;
  logic [0:0]  data_out;
  logic        unlocked;
  logic        lockout;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  // exp packs {write_en, data_out, unlocked, lockout, fail_cnt}
  typedef struct {
    string       name;
    logic        kv;
    logic [15:0] kd;
    logic        wr;
    logic        wd;
    logic        rl;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  lock_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_data  (key_data),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .relock    (relock),
    .write_en  (write_en),
    .data_out  (data_out),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b (we,do,un,lo,fc)", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic kv, input logic [15:0] kd, input logic wr,
                     input logic wd, input logic rl, input logic we, input logic dout,
                     input logic un, input logic lo, input logic [1:0] fc);
    vec_t v;
    v.name = n; v.kv = kv; v.kd = kd; v.wr = wr; v.wd = wd; v.rl = rl;
    v.exp  = {we, dout, un, lo, fc};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    key_valid = 1'b0; key_data = '0; wr_req = 1'b0; wr_data = '0; relock = 1'b0;
  endtask

  task automatic run_vecs();
    vec_t cur;
    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].kv; key_data = vecs[i].kd;
      wr_req = vecs[i].wr; wr_data = vecs[i].wd; relock = vecs[i].rl;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      cur = exp_q.pop_front();
      check(cur.name, {write_en, data_out, unlocked, lockout, fail_cnt}, cur.exp);
    end
    vecs.delete();
    idle_inputs();
  endtask

  task automatic do_reset(input string n);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check(n, {write_en, data_out, unlocked, lockout, fail_cnt}, 6'b0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset("reset_state");

    // Basic unlock, full window, write on final window cycle, drop when locked.
    add("p1_key_a", 1, 16'hA5A5, 0, 0, 0, 0, 0, 0, 0, 0);
    add("p1_key_b", 1, 16'h5A5A, 0, 0, 0, 0, 0, 1, 0, 0);
    add("p1_wr_w1", 0, 16'h0,    1, 1, 0, 1, 1, 1, 0, 0);
    for (int i = 2; i <= 7; i++) add($sformatf("p1_idle_w%0d", i), 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add("p1_wr_w8", 0, 16'h0,    1, 0, 0, 1, 0, 0, 0, 0);
    add("p1_wr_lk", 0, 16'h0,    1, 1, 0, 0, 0, 0, 0, 0);
    run_vecs();

    // wr_req every cycle: eight pulses, ninth request dropped.
    add("p2_key_a", 1, 16'hA5A5, 0, 0, 0, 0, 0, 0, 0, 0);
    add("p2_key_b", 1, 16'h5A5A, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      add($sformatf("p2_wr%0d", i), 0, 0, 1, iv[0], 0, 1, iv[0], (i < 7), 0, 0);
    end
    add("p2_wr8", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    run_vecs();

    // Arm timeout, KEY_B on last arm cycle, relock with write, relock while armed.
    add("p3_key_a", 1, 16'hA5A5, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("p3_armwait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("p3_timeout", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("p3_key_a2", 1, 16'hA5A5, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("p3_armwait2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("p3_key_b_t1", 1, 16'h5A5A, 0, 0, 0, 0, 1, 1, 0, 0);
    add("p3_relock_wr", 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    add("p3_key_a3", 1, 16'hA5A5, 0, 0, 0, 0, 1, 0, 0, 0);
    add("p3_relock_arm", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add("p3_b_locked", 1, 16'h5A5A, 0, 0, 0, 0, 1, 0, 0, 1);
    add("p3_key_a4", 1, 16'hA5A5, 0, 0, 0, 0, 1, 0, 0, 1);
    add("p3_a_twice", 1, 16'hA5A5, 0, 0, 0, 0, 1, 0, 0, 2);
    run_vecs();

    // Lockout after three wrong keys; correct sequence and relock are ignored.
    do_reset("p4_reset");
    add("p4_bad1", 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 1);
    add("p4_bad2", 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 2);
    add("p4_bad3", 1, 16'h1234, 0, 0, 0, 0, 0, 0, 1, 3);
    add("p4_lo_a", 1, 16'hA5A5, 0, 0, 0, 0, 0, 0, 1, 3);
    add("p4_lo_b", 1, 16'h5A5A, 0, 0, 0, 0, 0, 0, 1, 3);
    add("p4_lo_wr", 0, 0, 1, 1, 0, 0, 0, 0, 1, 3);
    add("p4_lo_relock", 0, 0, 0, 0, 1, 0, 0, 0, 1, 3);
    run_vecs();
    do_reset("p4_reset_clears");

    // Asynchronous reset mid-window while a write is on the outputs.
    add("p5_key_a", 1, 16'hA5A5, 0, 0, 0, 0, 0, 0, 0, 0);
    add("p5_key_b", 1, 16'h5A5A, 0, 0, 0, 0, 0, 1, 0, 0);
    add("p5_wr", 0, 0, 1, 1, 0, 1, 1, 1, 0, 0);
    run_vecs();
    #2 reset = 1'b1;
    #1;
    check("p5_async_reset", {write_en, data_out, unlocked, lockout, fail_cnt}, 6'b0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("p5_after_reset", {write_en, data_out, unlocked, lockout, fail_cnt}, 6'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
